// File: rtl/dcache_line_refill_pkg.sv
// Shared data-cache refill definitions: line geometry, FSM encoding and AXI burst constants.
package dcache_line_refill_pkg;

    localparam int LINE_WORDS = 8;
    localparam int OFF_W      = 3;   // word offset within a line
    localparam int WORD_LSB   = 2;   // byte address -> word offset
    localparam int LINE_LSB   = 5;   // byte address -> line index

    localparam logic [7:0] AXI_ARLEN      = 8'd7;
    localparam logic [2:0] AXI_ARSIZE     = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_WB   = 2'd3
    } refill_state_e;

    function automatic logic [OFF_W-1:0] word_offset(input logic [31:0] byte_addr);
        return byte_addr[LINE_LSB-1:WORD_LSB];
    endfunction

endpackage

// File: rtl/dcache_line_refill_if.sv
// AXI read-channel bundle (AR + R) between the refill engine and the memory interconnect.
interface dcache_line_refill_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arid;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rlast, rresp
    );
endinterface

// File: rtl/dcache_line_refill_line_pack.sv
// Line assembly register: one slot per word, written by beat index, read out as a packed line.
module refill_line_pack
    import dcache_line_refill_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [OFF_W-1:0]                      wr_idx,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    output logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line
);

    logic [DATA_WIDTH-1:0] slot [LINE_WORDS];

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                slot[k] <= '0;
            else if (wr_en && wr_idx == OFF_W'(k))
                slot[k] <= wr_data;
        end

        assign line[k] = slot[k];
    end

endmodule

// File: rtl/dcache_line_refill.sv
// Data-cache refill engine: one 8-beat AXI INCR read per miss, early critical-word forward,
// then a single-cycle full-line write into the line BRAM.
module dcache_line_refill
    import dcache_line_refill_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      miss_req,
    input  logic [31:0]               miss_addr,
    output logic                      busy,

    dcache_line_refill_if.master      axi,

    output logic                      crit_valid,
    output logic [DATA_WIDTH-1:0]     crit_data,

    output logic                      line_we,
    output logic [ADDR_WIDTH-1:0]     line_waddr,
    output logic [DATA_WIDTH*8-1:0]   line_data,
    output logic                      refill_done,
    output logic                      refill_err
);

    refill_state_e state, state_nxt;

    logic [31-LINE_LSB:0] addr_hi;     // miss_addr[31:5]; low bits give the BRAM line index
    logic [OFF_W-1:0]     crit_off;
    logic [OFF_W-1:0]     cnt;
    logic                 err;

    logic                 beat;
    logic                 last_slot;
    logic                 accept;

    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_pk;

    // Byte-lane bits never matter for a word-granular refill.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^miss_addr[WORD_LSB-1:0];

    assign accept    = (state == ST_IDLE) && miss_req;
    assign beat      = (state == ST_R) && axi.rvalid;
    assign last_slot = (cnt == OFF_W'(LINE_WORDS-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (miss_req)                 state_nxt = ST_AR;
            ST_AR:   if (axi.arready)              state_nxt = ST_R;
            // A premature rlast ends the burst early; the error flag already records it.
            ST_R:    if (beat && (last_slot || axi.rlast)) state_nxt = ST_WB;
            ST_WB:                                 state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hi  <= '0;
            crit_off <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            addr_hi  <= miss_addr[31:LINE_LSB];
            crit_off <= word_offset(miss_addr);
            cnt      <= '0;
            err      <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + OFF_W'(1);
            err <= err | (axi.rresp != 2'b00) | (axi.rlast != last_slot);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= beat && (cnt == crit_off);
            if (beat && (cnt == crit_off))
                crit_data <= axi.rdata;
        end
    end

    refill_line_pack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat),
        .wr_idx  (cnt),
        .wr_data (axi.rdata),
        .line    (line_pk)
    );

    assign busy        = (state != ST_IDLE);

    assign axi.arvalid = (state == ST_AR);
    assign axi.araddr  = {addr_hi, {LINE_LSB{1'b0}}};
    assign axi.arlen   = AXI_ARLEN;
    assign axi.arsize  = AXI_ARSIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid    = AXI_ID;
    assign axi.rready  = (state == ST_R);

    assign line_we     = (state == ST_WB) && !err;
    assign refill_done = (state == ST_WB) && !err;
    assign refill_err  = (state == ST_WB) && err;
    assign line_waddr  = {addr_hi[ADDR_WIDTH-4:0], {OFF_W{1'b0}}};
    assign line_data   = line_pk;

endmodule

// File: tb/tb_dcache_line_refill.sv
// Directed bench for dcache_line_refill: transaction-level model checked every cycle,
// plus literal expectations for latencies, addresses and critical-word data.
module tb_dcache_line_refill;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         busy;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         line_we;
    logic [9:0]   line_waddr;
    logic [255:0] line_data;
    logic         refill_done;
    logic         refill_err;

    always #5 clk = ~clk;

    dcache_line_refill_if #(.DATA_WIDTH(32)) axi ();

    dcache_line_refill #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .AXI_ID     (4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .busy        (busy),
        .axi         (axi.master),
        .crit_valid  (crit_valid),
        .crit_data   (crit_data),
        .line_we     (line_we),
        .line_waddr  (line_waddr),
        .line_data   (line_data),
        .refill_done (refill_done),
        .refill_err  (refill_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 address, 2 data, 3 writeback (values the outputs hold for the next cycle)
    int           m_phase = 0;
    logic [26:0]  m_hi = '0;
    int           m_off = 0;
    logic [31:0]  got [$];
    logic [31:0]  m_line [8];
    bit           m_err = 1'b0;
    bit           m_crit_v = 1'b0;
    logic [31:0]  m_crit_d = '0;

    always @(posedge clk or posedge rst) begin
        int  k;
        bit  last;
        if (rst) begin
            m_phase  = 0;
            m_hi     = '0;
            m_off    = 0;
            got.delete();
            m_err    = 1'b0;
            m_crit_v = 1'b0;
            m_crit_d = '0;
            for (int i = 0; i < 8; i++) m_line[i] = '0;
        end else begin
            m_crit_v = 1'b0;
            case (m_phase)
                0: if (miss_req) begin
                    m_hi  = miss_addr[31:5];
                    m_off = int'(miss_addr[4:2]);
                    got.delete();
                    m_err = 1'b0;
                    m_phase = 1;
                end
                1: if (axi.arready) m_phase = 2;
                2: if (axi.rvalid) begin
                    k = got.size();
                    got.push_back(axi.rdata);
                    m_line[k] = axi.rdata;
                    if (k == m_off) begin
                        m_crit_v = 1'b1;
                        m_crit_d = axi.rdata;
                    end
                    last = (k == 7);
                    if (axi.rresp != 2'b00) m_err = 1'b1;
                    if (axi.rlast != last)  m_err = 1'b1;
                    if (last || axi.rlast)  m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    int          n_we = 0, n_err = 0, n_ar = 0, n_arv = 0;
    int          t_we = 0, t_crit = 0;
    logic [31:0] crit_seen = '0;
    logic [31:0] ar_seen = '0;
    logic [255:0] exp_line;

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = m_line[k];
        chk("busy",        busy,        m_phase != 0);
        chk("arvalid",     axi.arvalid, m_phase == 1);
        chk("araddr",      axi.araddr,  {m_hi, 5'b0});
        chk("rready",      axi.rready,  m_phase == 2);
        chk("crit_valid",  crit_valid,  m_crit_v);
        if (m_crit_v) chk("crit_data", crit_data, m_crit_d);
        chk("line_we",     line_we,     m_phase == 3 && !m_err);
        chk("refill_done", refill_done, m_phase == 3 && !m_err);
        chk("refill_err",  refill_err,  m_phase == 3 && m_err);
        chk("line_waddr",  line_waddr,  {m_hi[6:0], 3'b000});
        chk("line_data",   line_data,   exp_line);

        if (line_we)    begin n_we++;  t_we = cyc; end
        if (refill_err) n_err++;
        if (crit_valid) begin t_crit = cyc; crit_seen = crit_data; end
        if (axi.arvalid) n_arv++;
        if (axi.arvalid && axi.arready) begin n_ar++; ar_seen = axi.araddr; end
    end

    // ---------------- stimulus ----------------
    int t_miss = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] addr, input int ar_wait, input logic [7:0] gaps,
                          input logic [31:0] base, input int nbeats, input int err_beat,
                          input int rlast_beat, input int miss_beat);
        miss_addr = addr;
        miss_req  = 1'b1;
        t_miss    = cyc;
        step();
        miss_req  = 1'b0;
        // beats offered before the address handshake must be ignored
        for (int w = 0; w < ar_wait; w++) begin
            axi.rvalid = (ar_wait > 0);
            axi.rdata  = 32'hBAD0_0000 + 32'(w);
            step();
        end
        axi.rvalid  = 1'b0;
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps[i]) begin
                axi.rdata = 32'hDEAD_BEEF;
                step();
            end
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(i);
            axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (i == rlast_beat);
            if (i == miss_beat) begin
                miss_req  = 1'b1;
                miss_addr = 32'h0000_0FC0;
            end
            step();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            axi.rresp  = 2'b00;
            miss_req   = 1'b0;
        end
        repeat (3) step();
    endtask

    int we0, err0, ar0, arv0;

    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rlast   = 1'b0;
        axi.rresp   = 2'b00;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset busy",      busy,        1'b0);
        chk("reset arvalid",   axi.arvalid, 1'b0);
        chk("reset line_we",   line_we,     1'b0);
        chk("reset line_data", line_data,   256'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // 1) zero-wait refill, critical word at offset 5
        we0 = n_we; ar0 = n_ar;
        refill(32'h0000_1234, 0, 8'h00, 32'hD000_0000, 8, -1, 7, -1);
        chk("t1 araddr",      ar_seen,        32'h0000_1220);
        chk("t1 arlen",       axi.arlen,      8'd7);
        chk("t1 arsize",      axi.arsize,     3'd2);
        chk("t1 arburst",     axi.arburst,    2'b01);
        chk("t1 arid",        axi.arid,       4'd0);
        chk("t1 line_waddr",  line_waddr,     10'h088);
        chk("t1 we latency",  t_we - t_miss,  10);
        chk("t1 crit lat",    t_crit - t_miss, 8);
        chk("t1 crit data",   crit_seen,      32'hD000_0005);
        chk("t1 word0",       line_data[31:0],    32'hD000_0000);
        chk("t1 word3",       line_data[127:96],  32'hD000_0003);
        chk("t1 word7",       line_data[255:224], 32'hD000_0007);
        chk("t1 we count",    n_we - we0,     1);
        chk("t1 ar count",    n_ar - ar0,     1);

        // 2) arready held off, gaps between beats
        we0 = n_we; arv0 = n_arv;
        refill(32'h0000_2468, 5, 8'b0101_0010, 32'hB000_0000, 8, -1, 7, -1);
        chk("t2 araddr",      ar_seen,        32'h0000_2460);
        chk("t2 arvalid cyc", n_arv - arv0,   6);
        chk("t2 we count",    n_we - we0,     1);
        chk("t2 line_waddr",  line_waddr,     10'h118);
        chk("t2 word2",       line_data[95:64],  32'hB000_0002);
        chk("t2 word6",       line_data[223:192], 32'hB000_0006);

        // 3) error response on beat 3, then a clean refill at offset 0
        we0 = n_we; err0 = n_err;
        refill(32'h0000_0100, 0, 8'h00, 32'hC000_0000, 8, 3, 7, -1);
        chk("t3 err count",   n_err - err0,   1);
        chk("t3 we count",    n_we - we0,     0);
        chk("t3 busy",        busy,           1'b0);
        we0 = n_we;
        refill(32'h0000_0040, 0, 8'h00, 32'h6000_0000, 8, -1, 7, -1);
        chk("t6a we count",   n_we - we0,     1);
        chk("t6a crit lat",   t_crit - t_miss, 3);
        chk("t6a crit data",  crit_seen,      32'h6000_0000);

        // 4) premature rlast on beat 4
        we0 = n_we; err0 = n_err;
        refill(32'h0000_0200, 0, 8'h00, 32'hE000_0000, 5, -1, 4, -1);
        chk("t4 err count",   n_err - err0,   1);
        chk("t4 we count",    n_we - we0,     0);
        chk("t4 busy",        busy,           1'b0);

        // 5) miss during data phase is dropped
        we0 = n_we; ar0 = n_ar;
        refill(32'h0000_0300, 0, 8'h00, 32'h1000_0000, 8, -1, 7, 2);
        chk("t5 ar count",    n_ar - ar0,     1);
        chk("t5 we count",    n_we - we0,     1);
        chk("t5 busy",        busy,           1'b0);

        // 5b) reset in the middle of the data phase
        miss_addr = 32'h0000_0500;
        miss_req  = 1'b1;
        step();
        miss_req    = 1'b0;
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'h5500_0000 + 32'(i);
            step();
        end
        axi.rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rst busy",      busy,        1'b0);
        chk("t5 rst rready",    axi.rready,  1'b0);
        chk("t5 rst line_data", line_data,   256'h0);
        chk("t5 rst araddr",    axi.araddr,  32'h0);
        step();
        rst = 1'b0;
        step();

        // 6) critical word at offset 7 arrives on the last beat
        we0 = n_we;
        refill(32'h0000_007C, 0, 8'h00, 32'h7000_0000, 8, -1, 7, -1);
        chk("t6b we count",   n_we - we0,      1);
        chk("t6b crit lat",   t_crit - t_miss, 10);
        chk("t6b we lat",     t_we - t_miss,   10);
        chk("t6b crit data",  crit_seen,       32'h7000_0007);
        chk("t6b line_waddr", line_waddr,      10'h018);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
